// File: rtl/nw_alignment_decoder.sv
// Turns the Needleman-Wunsch traceback coordinate stream into alignment columns.
// Classifies each step as match/mismatch/gap, emits over valid/ready and counts by type.
module nw_alignment_decoder #(
    parameter int LENGTH      = 10,
    parameter int CWIDTH      = 2,
    parameter int CORD_LENGTH = 8,
    parameter int BYTE_SIZE   = 2 * CORD_LENGTH,
    parameter int COUNT_WIDTH = CORD_LENGTH + 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [LENGTH*CWIDTH-1:0] s1,
    input  logic [LENGTH*CWIDTH-1:0] s2,
    input  logic                     in_valid,
    input  logic [BYTE_SIZE-1:0]     in_data,
    output logic                     in_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [1:0]               out_op,
    output logic [CWIDTH-1:0]        out_c1,
    output logic [CWIDTH-1:0]        out_c2,
    output logic                     out_last,
    output logic [COUNT_WIDTH-1:0]   match_count,
    output logic [COUNT_WIDTH-1:0]   mismatch_count,
    output logic [COUNT_WIDTH-1:0]   gap_count,
    output logic                     done,
    output logic                     error,
    input  logic                     start
);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StRun   = 3'd1;
    localparam logic [2:0] StEmit  = 3'd2;
    localparam logic [2:0] StDone  = 3'd3;
    localparam logic [2:0] StError = 3'd4;

    localparam logic [1:0] OpMatch    = 2'b00;
    localparam logic [1:0] OpMismatch = 2'b01;
    localparam logic [1:0] OpGapS1    = 2'b10;
    localparam logic [1:0] OpGapS2    = 2'b11;

    localparam logic [CORD_LENGTH-1:0] LastIdx = CORD_LENGTH'(LENGTH - 1);

    logic [2:0]             state_q, state_d;
    logic [CORD_LENGTH-1:0] prev_x_q, prev_x_d, prev_y_q, prev_y_d;
    logic                   out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic [1:0]             out_op_q, out_op_d;
    logic [CWIDTH-1:0]      out_c1_q, out_c1_d, out_c2_q, out_c2_d;
    logic [COUNT_WIDTH-1:0] match_q, match_d, mismatch_q, mismatch_d, gap_q, gap_d;
    logic                   done_q, done_d, error_q, error_d;

    logic [CORD_LENGTH-1:0] xn, yn;
    logic                   x_dec, y_dec, step_diag, step_gs1, step_gs2, step_ok;
    logic                   prev_zero, in_hs, out_hs;
    logic [CWIDTH-1:0]      c1_prev, c2_prev, c1_zero, c2_zero;
    logic [1:0]             step_op, zero_op;
    logic [CWIDTH-1:0]      step_c1, step_c2;

    function automatic logic [CWIDTH-1:0] char_at(input logic [LENGTH*CWIDTH-1:0] str,
                                                  input logic [CORD_LENGTH-1:0]   idx);
        char_at = '0;
        for (int i = 0; i < LENGTH; i++) begin
            if (idx == CORD_LENGTH'(i)) char_at = str[(LENGTH-1-i)*CWIDTH +: CWIDTH];
        end
    endfunction

    always_comb begin
        xn        = in_data[CORD_LENGTH +: CORD_LENGTH];
        yn        = in_data[0 +: CORD_LENGTH];
        // Non-zero guards reject underflow through the decrement.
        x_dec     = (prev_x_q != '0) && (xn == prev_x_q - 1'b1);
        y_dec     = (prev_y_q != '0) && (yn == prev_y_q - 1'b1);
        step_diag = x_dec && y_dec;
        step_gs2  = (xn == prev_x_q) && y_dec;
        step_gs1  = x_dec && (yn == prev_y_q);
        step_ok   = step_diag || step_gs1 || step_gs2;
        prev_zero = (prev_x_q == '0) && (prev_y_q == '0);

        c1_prev = char_at(s1, prev_y_q);
        c2_prev = char_at(s2, prev_x_q);
        c1_zero = s1[(LENGTH-1)*CWIDTH +: CWIDTH];
        c2_zero = s2[(LENGTH-1)*CWIDTH +: CWIDTH];
        zero_op = (c1_zero == c2_zero) ? OpMatch : OpMismatch;

        if (step_diag)     step_op = (c1_prev == c2_prev) ? OpMatch : OpMismatch;
        else if (step_gs2) step_op = OpGapS2;
        else               step_op = OpGapS1;
        step_c1 = step_gs1 ? '0 : c1_prev;
        step_c2 = step_gs2 ? '0 : c2_prev;
    end

    always_comb begin
        case (state_q)
            StIdle, StRun, StError: in_ready = reset;
            StEmit:                 in_ready = reset && out_ready && !prev_zero;
            default:                in_ready = 1'b0;
        endcase
    end

    assign in_hs  = in_valid && in_ready;
    assign out_hs = out_valid_q && out_ready;

    always_comb begin
        state_d     = state_q;
        prev_x_d    = prev_x_q;
        prev_y_d    = prev_y_q;
        out_valid_d = out_valid_q;
        out_op_d    = out_op_q;
        out_c1_d    = out_c1_q;
        out_c2_d    = out_c2_q;
        out_last_d  = out_last_q;
        done_d      = done_q;
        error_d     = error_q;
        match_d     = match_q;
        mismatch_d  = mismatch_q;
        gap_d       = gap_q;

        if (out_hs) begin
            case (out_op_q)
                OpMatch:    match_d    = match_q + COUNT_WIDTH'(1);
                OpMismatch: mismatch_d = mismatch_q + COUNT_WIDTH'(1);
                default:    gap_d      = gap_q + COUNT_WIDTH'(1);
            endcase
        end

        case (state_q)
            StIdle: begin
                if (in_hs) begin
                    if (xn == LastIdx && yn == LastIdx) begin
                        prev_x_d = xn;
                        prev_y_d = yn;
                        state_d  = StRun;
                    end else begin
                        state_d = StError;
                        error_d = 1'b1;
                    end
                end
            end
            StRun, StEmit: begin
                if (in_hs) begin
                    if (step_ok) begin
                        prev_x_d    = xn;
                        prev_y_d    = yn;
                        out_valid_d = 1'b1;
                        out_op_d    = step_op;
                        out_c1_d    = step_c1;
                        out_c2_d    = step_c2;
                        out_last_d  = 1'b0;
                        state_d     = StEmit;
                    end else begin
                        out_valid_d = 1'b0;
                        state_d     = StError;
                        error_d     = 1'b1;
                    end
                end else if (out_hs) begin
                    if (!prev_zero) begin
                        out_valid_d = 1'b0;
                        state_d     = StRun;
                    end else if (!out_last_q) begin
                        // The (0,0) cell itself still owes one diagonal column.
                        out_op_d   = zero_op;
                        out_c1_d   = c1_zero;
                        out_c2_d   = c2_zero;
                        out_last_d = 1'b1;
                    end else begin
                        out_valid_d = 1'b0;
                        state_d     = StDone;
                        done_d      = 1'b1;
                    end
                end
            end
            StDone, StError: begin
                if (start) begin
                    state_d    = StIdle;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    match_d    = '0;
                    mismatch_d = '0;
                    gap_d      = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            prev_x_q    <= '0;
            prev_y_q    <= '0;
            out_valid_q <= 1'b0;
            out_op_q    <= '0;
            out_c1_q    <= '0;
            out_c2_q    <= '0;
            out_last_q  <= 1'b0;
            match_q     <= '0;
            mismatch_q  <= '0;
            gap_q       <= '0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_x_q    <= prev_x_d;
            prev_y_q    <= prev_y_d;
            out_valid_q <= out_valid_d;
            out_op_q    <= out_op_d;
            out_c1_q    <= out_c1_d;
            out_c2_q    <= out_c2_d;
            out_last_q  <= out_last_d;
            match_q     <= match_d;
            mismatch_q  <= mismatch_d;
            gap_q       <= gap_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign out_op         = out_op_q;
    assign out_c1         = out_c1_q;
    assign out_c2         = out_c2_q;
    assign out_last       = out_last_q;
    assign match_count    = match_q;
    assign mismatch_count = mismatch_q;
    assign gap_count      = gap_q;
    assign done           = done_q;
    assign error          = error_q;

endmodule
